// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a framed program image as a byte stream, assembles bytes into
// instruction words, and writes them sequentially into the instruction RAM.
// The CPU pipeline is held in reset until an image has fully loaded with a
// matching checksum.
//
// Frame: SYNC, LEN_HI, LEN_LO, LEN x (HI, LO), CHK
//   CHK = XOR of every byte between SYNC and CHK.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   iRxData/iRxValid  incoming byte stream
//   oRxReady          always 1; the loader never back-pressures
//   oMemWrEn          one-cycle instruction RAM write strobe
//   oMemWrAddr/Data   write address/data, held between strobes
//   oCpuReset         high while no valid image is loaded
//   oDone / oError    result of the last frame, cleared when a new frame starts
//   oWordCount        words written in the current or last frame

`ifndef WIDTH_INSTR_MEM
`define WIDTH_INSTR_MEM 16
`endif
`ifndef LENGTH_INSTR_MEM
`define LENGTH_INSTR_MEM 10
`endif

module imem_loader #(
  parameter int unsigned DATA_W = `WIDTH_INSTR_MEM,
  parameter int unsigned ADDR_W = `LENGTH_INSTR_MEM,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        iRxData,
  input  logic              iRxValid,
  output logic              oRxReady,
  output logic              oMemWrEn,
  output logic [ADDR_W-1:0] oMemWrAddr,
  output logic [DATA_W-1:0] oMemWrData,
  output logic              oCpuReset,
  output logic              oDone,
  output logic              oError,
  output logic [ADDR_W:0]   oWordCount
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN_H,
    LEN_L,
    DAT_H,
    DAT_L,
    CHK,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] length;
  logic [7:0]  checksum;
  logic [7:0]  hi_byte;

  logic [15:0] len_full;
  logic [15:0] word_full;
  logic [ADDR_W:0] count_nxt;
  logic        len_ovf;
  logic        len_zero;
  logic        last_word;
  logic        chk_match;

  logic        start_frame;
  logic        sum_byte;
  logic        wr_fire;
  logic        load_ok;
  logic        load_bad;

  assign oRxReady  = 1'b1;

  assign len_full  = {length[15:8], iRxData};
  assign word_full = {hi_byte, iRxData};
  assign count_nxt = oWordCount + (ADDR_W+1)'(1);
  assign len_ovf   = 32'(len_full) > DEPTH;
  assign len_zero  = (len_full == 16'd0);
  assign last_word = (17'(count_nxt) == 17'(length));
  assign chk_match = (iRxData == checksum);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; only an accepted byte advances the FSM
  always_comb begin
    state_nxt = state;
    if (iRxValid) begin
      case (state)
        IDLE, DONE, ERROR: if (iRxData == SYNC) state_nxt = LEN_H;
        LEN_H:             state_nxt = LEN_L;
        LEN_L: begin
          if (len_ovf)       state_nxt = ERROR;
          else if (len_zero) state_nxt = CHK;
          else               state_nxt = DAT_H;
        end
        DAT_H:             state_nxt = DAT_L;
        DAT_L:             state_nxt = last_word ? CHK : DAT_H;
        CHK:               state_nxt = chk_match ? DONE : ERROR;
        default:           state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: per-byte actions that the registered outputs apply next edge
  always_comb begin
    start_frame = 1'b0;
    sum_byte    = 1'b0;
    wr_fire     = 1'b0;
    load_ok     = 1'b0;
    load_bad    = 1'b0;
    if (iRxValid) begin
      case (state)
        IDLE, DONE, ERROR: start_frame = (iRxData == SYNC);
        LEN_H, DAT_H:      sum_byte = 1'b1;
        LEN_L: begin
          sum_byte = 1'b1;
          load_bad = len_ovf;
        end
        DAT_L: begin
          sum_byte = 1'b1;
          wr_fire  = 1'b1;
        end
        CHK: begin
          load_ok  = chk_match;
          load_bad = !chk_match;
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oMemWrEn   <= 1'b0;
      oMemWrAddr <= '0;
      oMemWrData <= '0;
      oCpuReset  <= 1'b1;
      oDone      <= 1'b0;
      oError     <= 1'b0;
      oWordCount <= '0;
      length     <= '0;
      checksum   <= '0;
      hi_byte    <= '0;
    end else begin
      oMemWrEn <= wr_fire;

      if (start_frame) begin
        checksum   <= '0;
        oWordCount <= '0;
        oDone      <= 1'b0;
        oError     <= 1'b0;
        oCpuReset  <= 1'b1;
      end

      if (sum_byte) checksum <= checksum ^ iRxData;

      if (iRxValid && state == LEN_H) length[15:8] <= iRxData;
      if (iRxValid && state == LEN_L) length[7:0]  <= iRxData;
      if (iRxValid && state == DAT_H) hi_byte      <= iRxData;

      // Upper bits of the assembled word beyond DATA_W are dropped
      if (wr_fire) begin
        oMemWrAddr <= oWordCount[ADDR_W-1:0];
        oMemWrData <= word_full[DATA_W-1:0];
        oWordCount <= count_nxt;
      end

      if (load_ok) begin
        oCpuReset <= 1'b0;
        oDone     <= 1'b1;
      end

      if (load_bad) oError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int tests = 0;
  int fails = 0;

  imem_loader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SYNC  (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iRxData   (rx_data),
    .iRxValid  (rx_valid),
    .oRxReady  (rx_ready),
    .oMemWrEn  (wr_en),
    .oMemWrAddr(wr_addr),
    .oMemWrData(wr_data),
    .oCpuReset (cpu_reset),
    .oDone     (done),
    .oError    (error),
    .oWordCount(word_count)
  );

  always #5 clk = ~clk;

  // Write monitor
  logic [ADDR_W-1:0] cap_addr[$];
  logic [DATA_W-1:0] cap_data[$];
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  // Reference model: frame built from a word list, expectations from the frame rules
  logic [15:0]       wq[$];
  logic [7:0]        frm[$];
  bit                frm_strobe[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  bit                exp_done;
  bit                exp_err;
  int                exp_count;

  function automatic void build_frame(input int len_field, input bit junk,
                                      input bit force_chk, input logic [7:0] chk_val,
                                      input logic [7:0] corrupt);
    logic [7:0] sum;
    logic [7:0] chk;
    logic [15:0] lf;
    frm.delete(); frm_strobe.delete(); exp_addr.delete(); exp_data.delete();
    if (junk) begin
      frm.push_back(8'h00); frm_strobe.push_back(0);
      frm.push_back(8'hFF); frm_strobe.push_back(0);
      frm.push_back(8'h5A); frm_strobe.push_back(0);
    end
    lf = 16'(len_field);
    frm.push_back(8'hA5);  frm_strobe.push_back(0);
    frm.push_back(lf[15:8]); frm_strobe.push_back(0);
    frm.push_back(lf[7:0]);  frm_strobe.push_back(0);
    sum = lf[15:8] ^ lf[7:0];
    if (len_field > (1 << ADDR_W)) begin
      exp_done = 0; exp_err = 1; exp_count = 0;
      return;
    end
    for (int i = 0; i < len_field; i++) begin
      frm.push_back(wq[i][15:8]); frm_strobe.push_back(0);
      frm.push_back(wq[i][7:0]);  frm_strobe.push_back(1);
      sum = sum ^ wq[i][15:8] ^ wq[i][7:0];
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back(wq[i][DATA_W-1:0]);
    end
    chk = force_chk ? chk_val : (sum ^ corrupt);
    frm.push_back(chk); frm_strobe.push_back(0);
    exp_done  = (chk == sum);
    exp_err   = !exp_done;
    exp_count = len_field;
  endfunction

  task automatic run_frame(input string name, input bit gaps, input int start);
    cap_addr.delete(); cap_data.delete();
    for (int i = start; i < frm.size(); i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      @(negedge clk);
      if (i > start) begin
        tests++;
        if (wr_en !== frm_strobe[i-1]) begin
          fails++;
          $display("FAIL %s strobe after byte %0d: got %b expected %b", name, i-1, wr_en, frm_strobe[i-1]);
        end
      end
      for (int k = 0; k < g; k++) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = frm[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (done !== exp_done || error !== exp_err || cpu_reset !== !exp_done) begin
      fails++;
      $display("FAIL %s result: got done=%b err=%b cpu_reset=%b expected done=%b err=%b cpu_reset=%b",
               name, done, error, cpu_reset, exp_done, exp_err, !exp_done);
    end
    @(negedge clk);
    tests++;
    if (word_count !== (ADDR_W+1)'(exp_count)) begin
      fails++;
      $display("FAIL %s word_count: got %0d expected %0d", name, word_count, exp_count);
    end
    tests++;
    if (cap_addr.size() != exp_addr.size()) begin
      fails++;
      $display("FAIL %s write count: got %0d expected %0d", name, cap_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        tests++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          fails++;
          $display("FAIL %s write %0d: got (%0h,%0h) expected (%0h,%0h)",
                   name, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b0;
    #1 reset = 1'b1;
    #2;
    tests++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b1 ||
        wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || word_count !== '0) begin
      fails++;
      $display("FAIL reset values: got cpu_reset=%b done=%b err=%b ready=%b wr_en=%b addr=%0h data=%0h cnt=%0d expected 1 0 0 1 0 0 0 0",
               cpu_reset, done, error, rx_ready, wr_en, wr_addr, wr_data, word_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle hold: got cpu_reset=%b done=%b ready=%b expected 1 0 1", cpu_reset, done, rx_ready);
    end
  endtask

  task automatic test_basic_frame();
    wq = '{16'h400A, 16'h0000, 16'h40FF};
    build_frame(3, 0, 1, 8'hF6, 8'h00);
    run_frame("basic_frame", 0, 0);
  endtask

  task automatic test_bad_checksum();
    wq = '{16'h400A, 16'h0000, 16'h40FF};
    build_frame(3, 0, 1, 8'h00, 8'h00);
    run_frame("bad_checksum", 0, 0);
  endtask

  task automatic test_overflow();
    wq.delete();
    build_frame(1025, 0, 0, 8'h00, 8'h00);
    run_frame("overflow", 0, 0);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
    build_frame(4, 0, 0, 8'h00, 8'h00);
    run_frame("after_overflow", 0, 0);
  endtask

  task automatic test_zero_length();
    wq.delete();
    build_frame(0, 0, 0, 8'h00, 8'h00);
    run_frame("zero_length", 0, 0);
  endtask

  task automatic test_random_gaps();
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      if (r == 0) wq[0] = 16'hA5A5;  // SYNC value inside data
      build_frame(n, 1, 0, 8'h00,
                  ($urandom_range(0, 3) == 0) ? 8'(int'($urandom_range(1, 255))) : 8'h00);
      run_frame($sformatf("random_gaps_%0d", r), 1, 0);
    end
  endtask

  task automatic test_reset_midframe();
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    build_frame(4, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = frm[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (wr_en !== 1'b1) begin
      fails++;
      $display("FAIL midreset first strobe: got %b expected 1", wr_en);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || cpu_reset !== 1'b1 ||
        done !== 1'b0 || error !== 1'b0 || word_count !== '0) begin
      fails++;
      $display("FAIL midreset values: got wr_en=%b addr=%0h data=%0h cpu_reset=%b done=%b err=%b cnt=%0d expected 0 0 0 1 0 0 0",
               wr_en, wr_addr, wr_data, cpu_reset, done, error, word_count);
    end
    @(negedge clk);
    reset = 1'b0;
    cap_addr.delete(); cap_data.delete();
    for (int i = 5; i < frm.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = frm[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (cap_addr.size() != 0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL midreset aftermath: got writes=%0d cpu_reset=%b done=%b expected 0 1 0",
               cap_addr.size(), cpu_reset, done);
    end
  endtask

  task automatic test_resync_from_done();
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(16'($urandom));
    build_frame(3, 0, 0, 8'h00, 8'h00);
    run_frame("pre_resync", 0, 0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || word_count !== '0) begin
      fails++;
      $display("FAIL resync: got cpu_reset=%b done=%b cnt=%0d expected 1 0 0", cpu_reset, done, word_count);
    end
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
    build_frame(5, 0, 0, 8'h00, 8'h00);
    run_frame("post_resync", 1, 1);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_checksum();
    test_overflow();
    test_zero_length();
    test_random_gaps();
    test_reset_midframe();
    test_resync_from_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
